si5340_i2c_target: RTL and testbench
====================================

SI5340_I2C_TARGET -- requirements
Module: si5340_i2c_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h74, 7-bit I2C device address answered.
REQ-002 SHALL have parameter REG_AW, default 8, number of register-address LSBs that index the internal register file (2**REG_AW bytes).
REQ-003 SHALL have port clk_i, input, 1, the single clock for all logic.
REQ-004 SHALL have port arstn_i, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port scl_pad_i, input, 1, SCL line level.
REQ-006 SHALL have port sda_pad_i, input, 1, SDA line level.
REQ-007 SHALL have port sda_pad_o, output, 1, SDA drive value, tied 1'b0.
REQ-008 SHALL have port sda_padoen_o, output, 1, SDA output enable, active low (0 pulls SDA low).
REQ-009 SHALL have port wr_valid_o, output, 1, one-cycle pulse per accepted data byte.
REQ-010 SHALL have port wr_addr_o, output, 16, register address of the accepted byte.
REQ-011 SHALL have port wr_data_o, output, 8, accepted data byte.
REQ-012 SHALL have port busy_o, output, 1, high from an addressed START until STOP.

Function
REQ-013 SHALL pass SCL/SDA through 2-flop synchronisers, then detect SCL rise/fall, START (SDA fall while SCL high) and STOP (SDA rise while SCL high).
REQ-014 SHALL sample SDA on SCL rise, MSB first, and change sda_padoen_o only on SCL fall.
REQ-015 SHALL use FSM states IDLE, DEV, DEV_ACK, RA_HI, RA_HI_ACK, RA_LO, RA_LO_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-016 SHALL go to DEV on START from any state (repeated START included) and to IDLE on STOP from any state; STOP deasserts busy_o and releases SDA.
REQ-017 SHALL ACK in DEV_ACK only when the received address equals DEV_ADDR, else release SDA and go to IDLE until next START.
REQ-018 SHALL, when R/W=0, receive register-address high byte then low byte (each ACKed) into a 16-bit pointer, then receive data bytes into WDATA.
REQ-019 SHALL, per ACKed WDATA byte, write reg[ptr[REG_AW-1:0]], pulse wr_valid_o with wr_addr_o=ptr and wr_data_o=byte on the cycle following the 8th SCL rise, then increment ptr.
REQ-020 SHALL, when R/W=1, shift out reg[ptr[REG_AW-1:0]] starting on the SCL fall after DEV_ACK, increment ptr after each byte, and sample the master ACK on the 9th SCL rise.
REQ-021 SHALL continue reading on master ACK; on NACK, release SDA and wait in IDLE for STOP/START.
REQ-022 SHALL wrap ptr 16'hFFFF -> 16'h0000; ptr SHALL persist across transactions so a write-address-only transfer followed by a repeated-START read returns that address.
REQ-023 SHALL ignore ptr[15:REG_AW] for storage (aliasing) but report the full ptr on wr_addr_o.
REQ-024 SHALL hold each driven ACK or data bit through the whole SCL high phase and release SDA on the SCL fall ending the ACK bit.

Reset
REQ-025 SHALL, with arstn_i low at a clk_i edge, set state IDLE, sda_padoen_o=1, wr_valid_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, ptr=0, bit counter=0, synchronisers=1.
REQ-026 SHALL not reset register-file contents.
REQ-027 SHALL, on reset mid-transfer, release SDA on that edge and ignore the bus until the next START.

Structure
REQ-028 SHALL take DATA_WIDTH and the r_w READ/WRITE enum from cfg_pkg; DEV_ADDR default SHALL equal cfg_pkg SLAVE_ADDR.
REQ-029 SHALL put synchroniser and edge/START/STOP detection in sub-module i2c_line_sync.

Verification
REQ-030 SHALL cover write: START,0xE8,0x00,0x01,0x5A,STOP -> all 4 ACKed, wr_valid_o once with wr_addr_o=16'h0001, wr_data_o=8'h5A.
REQ-031 SHALL cover read: START,0xE8,0x00,0x01,Sr,0xE9, read 1 byte with NACK, STOP -> returns 8'h5A, SDA released after NACK.
REQ-032 SHALL cover wrong address: START,0xD0,... -> no ACK, no wr_valid_o, busy_o stays 0.
REQ-033 SHALL cover burst/wrap: write 0xFF,0xFF then 0x11,0x22 -> wr_addr_o 16'hFFFF then 16'h0000.
REQ-034 SHALL cover STOP after RA_HI only -> IDLE, no write; next transfer works normally.
REQ-035 SHALL cover arstn_i low while driving read bit 0 -> sda_padoen_o=1 on next edge; later valid transfer ACKed.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared configuration for the Si5340-style I2C register target.
// DATA_WIDTH : byte width on the bus and in the register file.
// SLAVE_ADDR : default 7-bit device address.
// r_w_e      : R/W bit of the address byte.
// state_e    : protocol FSM states of the target.
package cfg_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam logic [6:0]  SLAVE_ADDR = 7'h74;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } r_w_e;

    typedef enum logic [3:0] {
        StIdle,
        StDev,
        StDevAck,
        StRaHi,
        StRaHiAck,
        StRaLo,
        StRaLoAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRdataAck
    } state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronisers for SCL/SDA plus edge, START and STOP detection.
// clk_i, arstn_i : clock and synchronous active-low reset (all flops reset to 1)
// scl_i, sda_i   : raw bus line levels
// sda_o          : synchronised SDA level
// scl_rise_o     : one-cycle pulse on synchronised SCL rising edge
// scl_fall_o     : one-cycle pulse on synchronised SCL falling edge
// start_o        : one-cycle pulse, SDA fell while SCL high
// stop_o         : one-cycle pulse, SDA rose while SCL high
module i2c_line_sync (
    input  logic clk_i,
    input  logic arstn_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic scl_meta_q, scl_sync_q, scl_prev_q;
    logic sda_meta_q, sda_sync_q, sda_prev_q;

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_meta_q <= scl_i;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= sda_i;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
        end
    end

    assign sda_o      = sda_sync_q;
    assign scl_rise_o = scl_sync_q & ~scl_prev_q;
    assign scl_fall_o = ~scl_sync_q & scl_prev_q;
    // SCL must be high on both samples so an SDA change racing an SCL edge is not a condition
    assign start_o    = scl_sync_q & scl_prev_q & ~sda_sync_q & sda_prev_q;
    assign stop_o     = scl_sync_q & scl_prev_q & sda_sync_q & ~sda_prev_q;

endmodule

// File: rtl/si5340_i2c_target.sv
// I2C register target: 16-bit register pointer, byte register file of 2**REG_AW
// entries (upper pointer bits alias), auto-incrementing burst writes and reads.
// clk_i, arstn_i         : clock and synchronous active-low reset
// scl_pad_i, sda_pad_i   : bus line levels
// sda_pad_o              : SDA drive value, always 0 (open drain)
// sda_padoen_o           : SDA output enable, active low
// wr_valid_o             : one-cycle pulse per accepted data byte
// wr_addr_o, wr_data_o   : full pointer and data of the accepted byte
// busy_o                 : high from an addressed START until STOP
module si5340_i2c_target
    import cfg_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = SLAVE_ADDR,
    parameter int unsigned REG_AW   = 8
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic                  scl_pad_i,
    input  logic                  sda_pad_i,
    output logic                  sda_pad_o,
    output logic                  sda_padoen_o,
    output logic                  wr_valid_o,
    output logic [15:0]           wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  busy_o
);

    localparam int unsigned Depth = 2 ** REG_AW;

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync u_line_sync (
        .clk_i      (clk_i),
        .arstn_i    (arstn_i),
        .scl_i      (scl_pad_i),
        .sda_i      (sda_pad_i),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det)
    );

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [15:0]           ptr_q, ptr_d;
    r_w_e                  rw_q, rw_d;
    logic                  ack_q, ack_d;
    logic                  oen_q, oen_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [15:0]           wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  busy_q, busy_d;

    logic [DATA_WIDTH-1:0] mem_q [Depth];
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] rx_byte, rd_byte;

    assign rx_byte = {shift_q[DATA_WIDTH-2:0], sda_s};
    assign rd_byte = mem_q[ptr_q[REG_AW-1:0]];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        ack_d      = ack_q;
        oen_d      = oen_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
        mem_we     = 1'b0;

        if (start_det) begin
            state_d = StDev;
            cnt_d   = '0;
            oen_d   = 1'b1;
        end else if (stop_det) begin
            state_d = StIdle;
            cnt_d   = '0;
            oen_d   = 1'b1;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                StDev, StRaHi, StRaLo, StWdata: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = '0;
                            unique case (state_q)
                                StDev: begin
                                    rw_d    = r_w_e'(sda_s);
                                    state_d = StDevAck;
                                end
                                StRaHi: begin
                                    ptr_d[15:8] = rx_byte;
                                    state_d     = StRaHiAck;
                                end
                                StRaLo: begin
                                    ptr_d[7:0] = rx_byte;
                                    state_d    = StRaLoAck;
                                end
                                default: begin
                                    mem_we     = 1'b1;
                                    wr_valid_d = 1'b1;
                                    wr_addr_d  = ptr_q;
                                    wr_data_d  = rx_byte;
                                    ptr_d      = ptr_q + 16'd1;
                                    state_d    = StWdataAck;
                                end
                            endcase
                        end
                    end
                end
                // cnt_q = 0: waiting for the fall that opens the ACK bit;
                // cnt_q = 1: ACK driven, waiting for the fall that closes it.
                StDevAck, StRaHiAck, StRaLoAck, StWdataAck: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd0) begin
                            if (state_q == StDevAck && shift_q[7:1] != DEV_ADDR) begin
                                state_d = StIdle;
                            end else begin
                                oen_d = 1'b0;
                                cnt_d = 4'd1;
                                if (state_q == StDevAck) busy_d = 1'b1;
                            end
                        end else begin
                            oen_d = 1'b1;
                            cnt_d = '0;
                            unique case (state_q)
                                StDevAck: begin
                                    if (rw_q == READ) begin
                                        oen_d   = rd_byte[7];
                                        shift_d = {rd_byte[6:0], 1'b0};
                                        ptr_d   = ptr_q + 16'd1;
                                        state_d = StRdata;
                                    end else begin
                                        state_d = StRaHi;
                                    end
                                end
                                StRaHiAck: state_d = StRaLo;
                                default:   state_d = StWdata;
                            endcase
                        end
                    end
                end
                StRdata: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            oen_d   = 1'b1;
                            cnt_d   = '0;
                            state_d = StRdataAck;
                        end else begin
                            oen_d   = shift_q[7];
                            shift_d = {shift_q[6:0], 1'b0};
                        end
                    end
                end
                StRdataAck: begin
                    if (scl_rise) begin
                        ack_d = ~sda_s;
                    end else if (scl_fall) begin
                        if (ack_q) begin
                            oen_d   = rd_byte[7];
                            shift_d = {rd_byte[6:0], 1'b0};
                            ptr_d   = ptr_q + 16'd1;
                            state_d = StRdata;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            rw_q       <= WRITE;
            ack_q      <= 1'b0;
            oen_q      <= 1'b1;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
            oen_q      <= oen_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
        end
    end

    // Register file keeps its contents through reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[ptr_q[REG_AW-1:0]] <= rx_byte;
    end

    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = oen_q;
    assign wr_valid_o   = wr_valid_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_si5340_i2c_target.sv
// Directed bench for si5340_i2c_target: bit-banged I2C master, open-drain SDA
// model and a wr_valid_o monitor.
module tb_si5340_i2c_target;

    localparam int T = 8;  // clk cycles per quarter of an SCL bit

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        scl = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_bus;
    logic        sda_pad_o, sda_padoen_o, wr_valid_o, busy_o;
    logic [15:0] wr_addr_o;
    logic [7:0]  wr_data_o;

    int total = 0;
    int bad = 0;

    int          wr_seen = 0;
    int          busy_hi = 0;
    logic [15:0] mon_addr [16];
    logic [7:0]  mon_data [16];

    assign sda_bus = sda_m & (sda_padoen_o | sda_pad_o);

    always #5 clk = ~clk;

    si5340_i2c_target dut (
        .clk_i        (clk),
        .arstn_i      (arstn),
        .scl_pad_i    (scl),
        .sda_pad_i    (sda_bus),
        .sda_pad_o    (sda_pad_o),
        .sda_padoen_o (sda_padoen_o),
        .wr_valid_o   (wr_valid_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .busy_o       (busy_o)
    );

    always @(negedge clk) begin
        if (arstn && wr_valid_o) begin
            mon_addr[wr_seen % 16] <= wr_addr_o;
            mon_data[wr_seen % 16] <= wr_data_o;
            wr_seen <= wr_seen + 1;
        end
        if (arstn && busy_o) busy_hi <= busy_hi + 1;
    end

    task automatic wait_q();
        repeat (T) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; scl = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic i2c_rep_start();
        sda_m = 1'b1; wait_q();
        scl = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    // ack = 1 when the target pulled SDA low during the 9th bit
    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; wait_q();
            scl = 1'b1; wait_q();
            scl = 1'b0; wait_q();
        end
        sda_m = 1'b1; wait_q();
        scl = 1'b1; wait_q();
        ack = ~sda_bus;
        scl = 1'b0; wait_q();
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wait_q();
            scl = 1'b1; wait_q();
            b[i] = sda_bus;
            scl = 1'b0;
        end
        wait_q();
        sda_m = ~mack; wait_q();
        scl = 1'b1; wait_q();
        scl = 1'b0; wait_q();
        sda_m = 1'b1;
    endtask

    task automatic test_reset();
        arstn = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (sda_padoen_o !== 1'b1) begin bad++; $display("FAIL reset_oen got=%b exp=1", sda_padoen_o); end
        total++; if (wr_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", wr_valid_o); end
        total++; if (wr_addr_o !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h exp=0000", wr_addr_o); end
        total++; if (wr_data_o !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", wr_data_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        total++; if (sda_pad_o !== 1'b0) begin bad++; $display("FAIL reset_pad_o got=%b exp=0", sda_pad_o); end
        arstn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write();
        logic [3:0] acks;
        int base = wr_seen;
        i2c_start();
        write_byte(8'hE8, acks[3]);
        write_byte(8'h00, acks[2]);
        write_byte(8'h01, acks[1]);
        write_byte(8'h5A, acks[0]);
        total++; if (acks !== 4'b1111) begin bad++; $display("FAIL wr_acks got=%b exp=1111", acks); end
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL wr_busy_mid got=%b exp=1", busy_o); end
        i2c_stop();
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL wr_busy_end got=%b exp=0", busy_o); end
        total++; if (wr_seen - base !== 1) begin bad++; $display("FAIL wr_count got=%0d exp=1", wr_seen - base); end
        total++; if (mon_addr[base % 16] !== 16'h0001) begin bad++; $display("FAIL wr_addr got=%h exp=0001", mon_addr[base % 16]); end
        total++; if (mon_data[base % 16] !== 8'h5A) begin bad++; $display("FAIL wr_data got=%h exp=5a", mon_data[base % 16]); end
        total++; if (sda_padoen_o !== 1'b1) begin bad++; $display("FAIL wr_released got=%b exp=1", sda_padoen_o); end
    endtask

    task automatic test_read();
        logic [3:0] acks;
        logic [7:0] rd;
        int base = wr_seen;
        i2c_start();
        write_byte(8'hE8, acks[3]);
        write_byte(8'h00, acks[2]);
        write_byte(8'h01, acks[1]);
        i2c_rep_start();
        write_byte(8'hE9, acks[0]);
        read_byte(1'b0, rd);
        total++; if (acks !== 4'b1111) begin bad++; $display("FAIL rd_acks got=%b exp=1111", acks); end
        total++; if (rd !== 8'h5A) begin bad++; $display("FAIL rd_data got=%h exp=5a", rd); end
        total++; if (sda_padoen_o !== 1'b1) begin bad++; $display("FAIL rd_nack_release got=%b exp=1", sda_padoen_o); end
        i2c_stop();
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rd_busy_end got=%b exp=0", busy_o); end
        total++; if (wr_seen - base !== 0) begin bad++; $display("FAIL rd_no_write got=%0d exp=0", wr_seen - base); end
    endtask

    task automatic test_wrong_addr();
        logic a0, a1;
        int base = wr_seen;
        int bbase = busy_hi;
        i2c_start();
        write_byte(8'hD0, a0);
        write_byte(8'h00, a1);
        i2c_stop();
        total++; if (a0 !== 1'b0) begin bad++; $display("FAIL wa_addr_ack got=%b exp=0", a0); end
        total++; if (a1 !== 1'b0) begin bad++; $display("FAIL wa_byte_ack got=%b exp=0", a1); end
        total++; if (wr_seen - base !== 0) begin bad++; $display("FAIL wa_no_write got=%0d exp=0", wr_seen - base); end
        total++; if (busy_hi - bbase !== 0) begin bad++; $display("FAIL wa_busy_cycles got=%0d exp=0", busy_hi - bbase); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] acks;
        logic [3:0] racks;
        logic [7:0] r0, r1;
        int base = wr_seen;
        i2c_start();
        write_byte(8'hE8, acks[4]);
        write_byte(8'hFF, acks[3]);
        write_byte(8'hFF, acks[2]);
        write_byte(8'h11, acks[1]);
        write_byte(8'h22, acks[0]);
        i2c_stop();
        total++; if (acks !== 5'b11111) begin bad++; $display("FAIL wrap_acks got=%b exp=11111", acks); end
        total++; if (wr_seen - base !== 2) begin bad++; $display("FAIL wrap_count got=%0d exp=2", wr_seen - base); end
        total++; if (mon_addr[base % 16] !== 16'hFFFF) begin bad++; $display("FAIL wrap_addr0 got=%h exp=ffff", mon_addr[base % 16]); end
        total++; if (mon_data[base % 16] !== 8'h11) begin bad++; $display("FAIL wrap_data0 got=%h exp=11", mon_data[base % 16]); end
        total++; if (mon_addr[(base + 1) % 16] !== 16'h0000) begin bad++; $display("FAIL wrap_addr1 got=%h exp=0000", mon_addr[(base + 1) % 16]); end
        total++; if (mon_data[(base + 1) % 16] !== 8'h22) begin bad++; $display("FAIL wrap_data1 got=%h exp=22", mon_data[(base + 1) % 16]); end
        // 0x00FF aliases 0xFFFF, then 0x0100 aliases 0x0000
        i2c_start();
        write_byte(8'hE8, racks[3]);
        write_byte(8'h00, racks[2]);
        write_byte(8'hFF, racks[1]);
        i2c_rep_start();
        write_byte(8'hE9, racks[0]);
        read_byte(1'b1, r0);
        read_byte(1'b0, r1);
        i2c_stop();
        total++; if (racks !== 4'b1111) begin bad++; $display("FAIL alias_acks got=%b exp=1111", racks); end
        total++; if (r0 !== 8'h11) begin bad++; $display("FAIL alias_rd0 got=%h exp=11", r0); end
        total++; if (r1 !== 8'h22) begin bad++; $display("FAIL alias_rd1 got=%h exp=22", r1); end
    endtask

    task automatic test_stop_after_rahi();
        logic [1:0] a;
        logic [3:0] acks;
        int base = wr_seen;
        i2c_start();
        write_byte(8'hE8, a[1]);
        write_byte(8'h12, a[0]);
        i2c_stop();
        total++; if (a !== 2'b11) begin bad++; $display("FAIL rahi_acks got=%b exp=11", a); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rahi_busy got=%b exp=0", busy_o); end
        total++; if (wr_seen - base !== 0) begin bad++; $display("FAIL rahi_no_write got=%0d exp=0", wr_seen - base); end
        i2c_start();
        write_byte(8'hE8, acks[3]);
        write_byte(8'h00, acks[2]);
        write_byte(8'h05, acks[1]);
        write_byte(8'h77, acks[0]);
        i2c_stop();
        total++; if (acks !== 4'b1111) begin bad++; $display("FAIL rahi_next_acks got=%b exp=1111", acks); end
        total++; if (wr_seen - base !== 1) begin bad++; $display("FAIL rahi_next_count got=%0d exp=1", wr_seen - base); end
        total++; if (mon_addr[base % 16] !== 16'h0005) begin bad++; $display("FAIL rahi_next_addr got=%h exp=0005", mon_addr[base % 16]); end
        total++; if (mon_data[base % 16] !== 8'h77) begin bad++; $display("FAIL rahi_next_data got=%h exp=77", mon_data[base % 16]); end
    endtask

    task automatic test_reset_mid_read();
        logic [3:0] setup, acks, acks2;
        logic [6:0] top7;
        int base;
        i2c_start();
        write_byte(8'hE8, setup[3]);
        write_byte(8'h00, setup[2]);
        write_byte(8'h10, setup[1]);
        write_byte(8'hFE, setup[0]);
        i2c_stop();
        i2c_start();
        write_byte(8'hE8, acks[3]);
        write_byte(8'h00, acks[2]);
        write_byte(8'h10, acks[1]);
        i2c_rep_start();
        write_byte(8'hE9, acks[0]);
        sda_m = 1'b1;
        for (int i = 6; i >= 0; i--) begin
            wait_q();
            scl = 1'b1; wait_q();
            top7[i] = sda_bus;
            scl = 1'b0;
        end
        wait_q();
        total++; if ({setup, acks} !== 8'hFF) begin bad++; $display("FAIL mid_acks got=%b exp=11111111", {setup, acks}); end
        total++; if (top7 !== 7'h7F) begin bad++; $display("FAIL mid_top7 got=%h exp=7f", top7); end
        total++; if (sda_padoen_o !== 1'b0) begin bad++; $display("FAIL mid_bit0_driven got=%b exp=0", sda_padoen_o); end
        arstn = 1'b0;
        @(negedge clk);
        total++; if (sda_padoen_o !== 1'b1) begin bad++; $display("FAIL mid_reset_release got=%b exp=1", sda_padoen_o); end
        arstn = 1'b1;
        scl = 1'b1; wait_q();
        scl = 1'b0; wait_q();
        i2c_stop();
        base = wr_seen;
        i2c_start();
        write_byte(8'hE8, acks2[3]);
        write_byte(8'h00, acks2[2]);
        write_byte(8'h20, acks2[1]);
        write_byte(8'h33, acks2[0]);
        i2c_stop();
        total++; if (acks2 !== 4'b1111) begin bad++; $display("FAIL post_reset_acks got=%b exp=1111", acks2); end
        total++; if (wr_seen - base !== 1) begin bad++; $display("FAIL post_reset_count got=%0d exp=1", wr_seen - base); end
        total++; if (mon_addr[base % 16] !== 16'h0020) begin bad++; $display("FAIL post_reset_addr got=%h exp=0020", mon_addr[base % 16]); end
        total++; if (mon_data[base % 16] !== 8'h33) begin bad++; $display("FAIL post_reset_data got=%h exp=33", mon_data[base % 16]); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wrong_addr();
        test_back_to_back();
        test_stop_after_rahi();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
